// File: rtl/mux4_sel_sequencer.sv
// Round-robin select sequencer that drives the 2-bit select of a 4:1 data mux.
// Latency: one cycle from a sampled request to valid; all outputs are registered.
// Backpressure: a grant is held until done, dwell expiry, en low or request
// withdrawal. One idle cycle always follows each grant.
// Optional macro MUXSEQ_TIMEOUT_FLAG_EN adds a 'timeout' output that flags
// releases caused only by dwell expiry.
module mux4_sel_sequencer #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       done,
`ifdef MUXSEQ_TIMEOUT_FLAG_EN
  output logic       timeout,
`endif
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       last, last_nxt;
  logic [1:0]       sel_nxt;
  logic [3:0]       grant_nxt;
  logic             valid_nxt;
  logic             busy_nxt;
  logic             timeout_nxt;
  logic             found;
  logic [1:0]       pick;
  logic [1:0]       cand;
  logic             expired;
  logic             rel;

  // Search order starts just after the last served source, so every requester
  // is reached within four arbitration rounds.
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    cand  = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next-state and next-output logic; several release causes collapse into one release.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    last_nxt    = last;
    sel_nxt     = sel;
    grant_nxt   = grant;
    valid_nxt   = valid;
    timeout_nxt = 1'b0;
    expired     = (cnt == CNT_W'(HOLD_CYCLES - 1));
    rel         = done || expired || !en || !req[sel];
    case (state)
      IDLE: begin
        if (en && found) begin
          state_nxt = GRANT;
          sel_nxt   = pick;
          grant_nxt = 4'b0001 << pick;
          valid_nxt = 1'b1;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        cnt_nxt = cnt + 1'b1;
        if (rel) begin
          state_nxt   = RELEASE;
          grant_nxt   = 4'b0000;
          valid_nxt   = 1'b0;
          last_nxt    = sel;
          timeout_nxt = expired && !done && en && req[sel];
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 4'b0000;
        valid_nxt = 1'b0;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State and registered outputs; reset clears them asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 2'd3;
      sel   <= 2'b00;
      grant <= 4'b0000;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
      sel   <= sel_nxt;
      grant <= grant_nxt;
      valid <= valid_nxt;
      busy  <= busy_nxt;
    end
  end

`ifdef MUXSEQ_TIMEOUT_FLAG_EN
  // Timeout flag is high only during the RELEASE cycle that follows a pure dwell expiry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) timeout <= 1'b0;
    else          timeout <= timeout_nxt;
  end
`endif

endmodule
